// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two W-bit operands (W = 4*NIBBLES) plus a carry-in,
// one 4-bit digit per clock, through a single 4-bit full adder.
// Optional signed-overflow output Ovf is built when NIBBLE_SERIAL_ADDER_OVF_EN
// is defined; the default build leaves the port and its logic out.
//
// Handshake: Start is a request. It is accepted on a rising edge in IDLE or
// DONE and ignored in RUN (Busy=1 tells the requester to hold off). Done pulses
// for exactly one cycle when Sum/Cout (and Ovf) take the new result. Sum/Cout
// keep that value until the next completion.

// 4-bit full adder: the only arithmetic element in the datapath.
module FullAdder_4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Five-bit add so the digit carry lands in cout.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 Start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 Cin,
  output logic                 Busy,
  output logic                 Done,
  output logic [4*NIBBLES-1:0] Sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic                 Cout,
  output logic                 Ovf
`else
  output logic                 Cout
`endif
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // FSM state is kept in state_q; checkers bind to state_q and idx_q directly.
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     psum_q, psum_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Datapath nets around the shared digit adder.
  logic [3:0]   a_nib;
  logic [3:0]   b_nib;
  logic [3:0]   fa_sum;
  logic         fa_cout;
  logic [W-1:0] psum_ins;

  // Pick the current digit of each latched operand.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*4 +: 4];
        b_nib = b_q[i*4 +: 4];
      end
    end
  end

  FullAdder_4Bit u_fa (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Partial sum with this cycle's digit dropped into its slot; on the last
  // digit this is the complete result.
  always_comb begin
    psum_ins = psum_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        psum_ins[i*4 +: 4] = fa_sum;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      // DONE accepts a new request just like IDLE, giving back-to-back
      // operation with no idle gap.
      S_IDLE, S_DONE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          psum_d  = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      // Start is deliberately not looked at here: a request in flight is
      // never disturbed.
      S_RUN: begin
        carry_d = fa_cout;
        psum_d  = psum_ins;
        if (idx_q == LAST_IDX) begin
          sum_d   = psum_ins;
          cout_d  = fa_cout;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = S_DONE;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          // Signed overflow: like-signed operands giving an opposite-signed sum.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (psum_ins[W-1] != a_q[W-1]);
`endif
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (NIBBLES=4). Directed steps in one initial
// block; a negedge monitor pops expected results when Done pulses.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to also check the Ovf output.
module tb_nibble_serial_adder;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset_n;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         Ovf;
`endif

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Cin     (Cin),
    .Busy    (Busy),
    .Done    (Done),
    .Sum     (Sum),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .Cout    (Cout),
    .Ovf     (Ovf)
`else
    .Cout    (Cout)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];      // {Cout, Sum}
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic       exp_ovf_q[$];
`endif
  int tests_run = 0;
  int fail_cnt  = 0;
  int done_cnt  = 0;
  logic done_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full-width integer add of the operands present at acceptance.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_q.push_back(s);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    exp_ovf_q.push_back((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]));
`endif
  endtask

  task automatic drop_last_exp();
    void'(exp_q.pop_back());
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    void'(exp_ovf_q.pop_back());
`endif
  endtask

  // Monitor: compare on every Done pulse, and make sure Done never lasts two cycles.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && Done === 1'b1) begin
      logic [W:0] want;
      done_cnt++;
      tests_run++;
      assert (done_prev === 1'b0) else begin
        fail_cnt++;
        $error("FAIL done_width: got two-cycle Done want one-cycle pulse");
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        fail_cnt++;
        $error("FAIL done_unexpected: got Done with sum 0x%0h want no Done", Sum);
      end else begin
        want = exp_q.pop_front();
        assert ({Cout, Sum} === want) else begin
          fail_cnt++;
          $error("FAIL result: got cout=%b sum=0x%04h want cout=%b sum=0x%04h",
                 Cout, Sum, want[W], want[W-1:0]);
        end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        begin
          logic wo;
          wo = exp_ovf_q.pop_front();
          tests_run++;
          assert (Ovf === wo) else begin
            fail_cnt++;
            $error("FAIL ovf: got %b want %b", Ovf, wo);
          end
        end
`endif
      end
    end
    done_prev = Done;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge: present a request, let one edge accept it, drop Start.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    A     = a;
    B     = b;
    Cin   = cin;
    Start = 1'b1;
    push_exp(a, b, cin);
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Bounded wait for Done, then step one more cycle.
  task automatic wait_done();
    int n;
    n = 0;
    while (Done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", {31'b0, (n < 40)}, 32'd1);
    @(negedge clk);
  endtask

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed steps ----------------
  initial begin
    int d0;
    reset_n = 1'b0;
    Start   = 1'b0;
    A       = '0;
    B       = '0;
    Cin     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_sum",  Sum,  0);
    check("rst_cout", Cout, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1 + 1: Busy for four cycles, Done after the fourth edge.
    issue(16'h0001, 16'h0001, 1'b0);
    for (int j = 0; j < 4; j++) begin
      check("lat_busy", Busy, 1);
      check("lat_done_low", Done, 0);
      @(negedge clk);
    end
    check("lat_done_high", Done, 1);
    check("lat_busy_low", Busy, 0);
    @(negedge clk);
    check("done_falls", Done, 0);

    // Carry through every digit, and a mixed pattern with carry-in.
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_done();
    issue(16'h0E3F, 16'h0911, 1'b1);
    wait_done();

    // Start during RUN with new operands is ignored; Sum holds 0x1751.
    issue(16'h0001, 16'h0002, 1'b0);
    d0 = done_cnt;
    Start = 1'b1;
    A     = 16'h1234;
    B     = 16'h1234;
    Cin   = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("sum_hold_run", Sum, 32'h1751);
    check("busy_run", Busy, 1);
    wait_done();
    repeat (3) @(negedge clk);
    check("single_done", done_cnt - d0, 1);

    // Signed-overflow patterns (Sum/Cout always, Ovf when built).
    issue(16'h7FFF, 16'h0001, 1'b0);
    wait_done();
    issue(16'h8000, 16'h8000, 1'b0);
    wait_done();

    // Random single operations.
    for (int r = 0; r < 4; r++) begin
      issue(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)));
      wait_done();
    end

    // Start held high: a result every 5 cycles, operands wiggled while in flight.
    Start = 1'b1;
    for (int n = 0; n < 5; n++) begin
      if (n == 4) begin
        A = 16'h4321; B = 16'h1234; Cin = 1'b0;
      end else begin
        A = 16'($urandom_range(0, 65535));
        B = 16'($urandom_range(0, 65535));
        Cin = 1'($urandom_range(0, 1));
      end
      push_exp(A, B, Cin);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (c < 4) begin
          A   = 16'($urandom_range(0, 65535));
          B   = 16'($urandom_range(0, 65535));
          Cin = 1'($urandom_range(0, 1));
        end
      end
      check("b2b_done", Done, 1);
    end
    Start = 1'b0;
    @(negedge clk);
    check("b2b_idle_busy", Busy, 0);

    // Reset in the middle of RUN: outputs clear at once, no Done afterwards.
    issue(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_sum",  Sum,  0);
    check("abort_cout", Cout, 0);
    drop_last_exp();
    @(negedge clk);
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    issue(16'h00FF, 16'h0F01, 1'b0);
    check("post_rst_busy", Busy, 1);
    wait_done();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: NIBBLES, default 4, number of 4-bit digits per operand; operand width W = 4*NIBBLES.
REQ-003 Port: clk, input, 1, rising-edge clock.
REQ-004 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port: Start, input, 1, request to add A+B+Cin.
REQ-006 Port: A, input, W, operand A.
REQ-007 Port: B, input, W, operand B.
REQ-008 Port: Cin, input, 1, carry into nibble 0.
REQ-009 Port: Busy, output, 1, high while a nibble addition is in progress.
REQ-010 Port: Done, output, 1, one-cycle pulse when Sum/Cout are updated.
REQ-011 Port: Sum, output, W, registered result.
REQ-012 Port: Cout, output, 1, registered carry out of the top nibble.

Function
REQ-013 The block SHALL add one nibble per clock, using one FullAdder_4Bit instance as its only adder.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE, with Start=1 at a rising edge: latch A, B and Cin into internal operand registers, clear the nibble index to 0, and go to RUN.
REQ-016 In RUN, each edge SHALL add:
- inputs: nibble[index] of A and B, plus the carry register (the latched Cin for index 0);
- stores: the 4-bit result into the partial-sum register at nibble position index, and the adder's carry into the carry register;
- then: increment index.
REQ-017 When index = NIBBLES-1 in RUN, that same edge SHALL:
- copy the full partial sum to Sum and the final carry to Cout;
- set Done=1;
- go to DONE.
REQ-018 Latency SHALL be as follows:
- Start sampled at edge k;
- Sum, Cout and Done valid after edge k+NIBBLES;
- Done high for exactly one cycle.
REQ-019 Busy SHALL be 1 exactly while the state is RUN.
REQ-020 Start while in RUN SHALL be ignored, with no effect on the operands or the result.
REQ-021 DONE SHALL last one cycle:
- Start=1 at that edge: accepted as in REQ-015 (back-to-back, no IDLE cycle), Done falls;
- Start=0: go to IDLE.
REQ-022 Sum and Cout SHALL hold their last value until the next completion; they do not change during RUN.
REQ-023 Changes on A, B and Cin after Start is accepted SHALL NOT affect the result in flight.
REQ-024 The result SHALL equal (A + B + Cin) mod 2^W, and Cout SHALL be bit W of the (W+1)-bit true sum.
REQ-025 The index counter SHALL be ceil(log2(NIBBLES)) bits wide, minimum 1, and SHALL never exceed NIBBLES-1.

Reset
REQ-026 reset_n=0 SHALL immediately, without waiting for a clock, do all of the following:
- force the state to IDLE;
- clear index, operand, partial-sum and carry registers;
- set Sum=0, Cout=0, Done=0, Busy=0.
REQ-027 Reset asserted during RUN SHALL abort the operation; no Done pulse follows for the aborted request.
REQ-028 The first Start accepted after reset_n rises SHALL behave exactly as REQ-015.

Configuration
REQ-029 The macro NIBBLE_SERIAL_ADDER_OVF_EN SHALL control a signed-overflow output.
REQ-030 With the macro defined:
- add output port Ovf, 1 bit;
- Ovf is registered at the completion edge as (A[W-1]==B[W-1]) && (Sum[W-1]!=A[W-1]), using the latched operands;
- Ovf resets to 0 and holds like Sum.
REQ-031 With the macro undefined, port Ovf and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (NIBBLES=4)
REQ-032 The bench SHALL cover: A=0x0001, B=0x0001, Cin=0, Start one cycle -> Busy for 4 cycles; Done at the 4th edge after Start; Sum=0x0002, Cout=0.
REQ-033 The bench SHALL cover: A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1. Also A=0x0E3F, B=0x0911, Cin=1 -> Sum=0x1751, Cout=0.
REQ-034 The bench SHALL cover, with the macro defined: A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, Ovf=1. Also A=0x8000, B=0x8000 -> Sum=0x0000, Cout=1, Ovf=1.
REQ-035 The bench SHALL cover: Start=1 with A=0x1234 during RUN of 0x0001+0x0002 -> ignored; Sum=0x0003 and one Done pulse only.
REQ-036 The bench SHALL cover: Start held high continuously with changing operands -> results every 5 cycles; each Sum matches the operands present at its accepting edge.
REQ-037 The bench SHALL cover: reset_n pulsed low at the 2nd RUN edge -> outputs 0 at once; no Done; the next Start gives the correct result.
